mux_seq_ctrl: RTL and testbench

//  Controller that sequences the two-lane constant/data mux unit: drives sel_0/sel_1 for a commanded run.

---
 rtl/mux_seq_ctrl_if.sv | 35 +++
 rtl/mux_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_mux_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_seq_ctrl_if.sv
// Command, mux-feedback and status signals between a command source, the two-lane
// mux unit and the mux_seq_ctrl sequencer.
interface mux_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_sel0;
    logic [1:0]       cmd_sel1;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_step;
    logic             abort;
    logic [WIDTH-1:0] mux_out_0;
    logic [WIDTH-1:0] mux_out_1;
    logic [1:0]       sel_0;
    logic [1:0]       sel_1;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] result;
    logic             overflow;

    modport master (
        output cmd_valid, cmd_sel0, cmd_sel1, cmd_len, cmd_step, abort,
        output mux_out_0, mux_out_1,
        input  cmd_ready, sel_0, sel_1, busy, done, result, overflow
    );

    modport slave (
        input  cmd_valid, cmd_sel0, cmd_sel1, cmd_len, cmd_step, abort,
        input  mux_out_0, mux_out_1,
        output cmd_ready, sel_0, sel_1, busy, done, result, overflow
    );
endinterface

// File: rtl/mux_seq_ctrl.sv
// Sequencer for the two-lane constant/data mux: steps the lane selects through a
// commanded run and accumulates both lane outputs every RUN cycle.
module mux_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int ACC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    mux_seq_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [1:0]       sel_0_q;
    logic [1:0]       sel_1_q;
    logic             step_q;
    logic [LEN_W-1:0] count;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W:0]   sum;

    // Top bit of the widened sum is the carry out of the ACC_W-bit accumulator.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return {1'b0, a} + {{(ACC_W+1-WIDTH){1'b0}}, x} + {{(ACC_W+1-WIDTH){1'b0}}, y};
    endfunction

    assign sum = acc_add(acc, bus.mux_out_0, bus.mux_out_1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_0_q <= 2'd0;
            sel_1_q <= 2'd0;
            step_q  <= 1'b0;
            count   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            acc     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.cmd_valid) begin
                        step_q  <= bus.cmd_step;
                        count   <= bus.cmd_len;
                        acc     <= '0;
                        ovf     <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            sel_0_q <= 2'd0;
                            sel_1_q <= 2'd0;
                        end else begin
                            state   <= RUN;
                            sel_0_q <= bus.cmd_sel0;
                            sel_1_q <= bus.cmd_sel1;
                        end
                    end
                end
                RUN: begin
                    // Abort wins over the accumulation of the cycle it is sampled in.
                    if (bus.abort) begin
                        state   <= IDLE;
                        sel_0_q <= 2'd0;
                        sel_1_q <= 2'd0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        acc   <= sum[ACC_W-1:0];
                        ovf   <= ovf | sum[ACC_W];
                        count <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            sel_0_q <= 2'd0;
                            sel_1_q <= 2'd0;
                        end else if (step_q) begin
                            sel_0_q <= sel_0_q + 2'd1;
                            sel_1_q <= sel_1_q + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    sel_0_q <= 2'd0;
                    sel_1_q <= 2'd0;
                end
                default: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    sel_0_q <= 2'd0;
                    sel_1_q <= 2'd0;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.sel_0     = sel_0_q;
    assign bus.sel_1     = sel_1_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = acc;
    assign bus.overflow  = ovf;

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Bench for mux_seq_ctrl: behavioural two-lane mux in the feedback path, vector
// table plus random runs through a result scoreboard, and abort/reset sequences.
module tb_mux_seq_ctrl;
    localparam int WIDTH = 8;
    localparam int LEN_W = 8;
    localparam int ACC_W = 9;

    logic clk = 1'b0;
    logic rst;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;

    always #5 clk = ~clk;

    mux_seq_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    mux_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Mux unit: lane 0 constants {in0,1,2,3}, lane 1 constants {in1,4,5,6}.
    assign bus.mux_out_0 = (bus.sel_0 == 2'd0) ? in0 : {6'd0, bus.sel_0};
    assign bus.mux_out_1 = (bus.sel_1 == 2'd0) ? in1 : ({6'd0, bus.sel_1} + 8'd3);

    typedef struct {
        logic [1:0] s0;
        logic [1:0] s1;
        logic [7:0] len;
        logic       step;
        logic [7:0] i0;
        logic [7:0] i1;
        logic [8:0] res;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [8:0] res;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic [1:0] a, b;
        logic [9:0] s;
        logic [7:0] x, y;
        e.res = '0;
        e.ovf = 1'b0;
        for (int k = 0; k < int'(v.len); k++) begin
            a = v.step ? 2'(v.s0 + 2'(k)) : v.s0;
            b = v.step ? 2'(v.s1 + 2'(k)) : v.s1;
            x = (a == 2'd0) ? v.i0 : {6'd0, a};
            y = (b == 2'd0) ? v.i1 : ({6'd0, b} + 8'd3);
            s = {1'b0, e.res} + {2'b0, x} + {2'b0, y};
            e.ovf = e.ovf | s[9];
            e.res = s[8:0];
        end
        return e;
    endfunction

    task automatic run(input vec_t v, input bit ab);
        exp_t e;
        bit seen;
        logic [1:0] es0, es1;
        seen = 1'b0;
        @(negedge clk);
        chk("ready_before_cmd", {31'd0, bus.cmd_ready}, 32'd1);
        bus.cmd_sel0  = v.s0;
        bus.cmd_sel1  = v.s1;
        bus.cmd_len   = v.len;
        bus.cmd_step  = v.step;
        bus.cmd_valid = 1'b1;
        bus.abort     = ab;
        in0 = v.i0;
        in1 = v.i1;
        sb.push_back('{res: v.res, ovf: v.ovf});
        @(posedge clk);
        for (int k = 1; k <= int'(v.len) + 3 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                bus.abort     = 1'b0;
                bus.cmd_sel0  = ~v.s0;
                bus.cmd_sel1  = ~v.s1;
                bus.cmd_len   = 8'hFF;
                bus.cmd_step  = ~v.step;
            end
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                chk("done_latency", k, int'(v.len) + 1);
                chk("done_busy", {31'd0, bus.busy}, 32'd1);
                chk("result", {23'd0, bus.result}, {23'd0, e.res});
                chk("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
            end else if (k <= int'(v.len)) begin
                es0 = v.step ? 2'(v.s0 + 2'(k - 1)) : v.s0;
                es1 = v.step ? 2'(v.s1 + 2'(k - 1)) : v.s1;
                chk("run_busy", {31'd0, bus.busy}, 32'd1);
                chk("run_sel_0", {30'd0, bus.sel_0}, {30'd0, es0});
                chk("run_sel_1", {30'd0, bus.sel_1}, {30'd0, es1});
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within %0d cycles, required at %0d", int'(v.len) + 3, int'(v.len) + 1);
            void'(sb.pop_front());
        end else begin
            @(negedge clk);
            chk("post_ready", {31'd0, bus.cmd_ready}, 32'd1);
            chk("post_busy", {31'd0, bus.busy}, 32'd0);
            chk("post_done", {31'd0, bus.done}, 32'd0);
            chk("post_sel", {30'd0, bus.sel_0 | bus.sel_1}, 32'd0);
            chk("post_result_hold", {23'd0, bus.result}, {23'd0, e.res});
        end
    endtask

    task automatic start(input logic [1:0] s0, input logic [1:0] s1, input logic [7:0] len,
                         input logic st, input logic [7:0] i0, input logic [7:0] i1);
        @(negedge clk);
        bus.cmd_sel0  = s0;
        bus.cmd_sel1  = s1;
        bus.cmd_len   = len;
        bus.cmd_step  = st;
        bus.cmd_valid = 1'b1;
        in0 = i0;
        in1 = i1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sel_0"}, {30'd0, bus.sel_0}, 32'd0);
        chk({tag, "_sel_1"}, {30'd0, bus.sel_1}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_result"}, {23'd0, bus.result}, 32'd0);
        chk({tag, "_overflow"}, {31'd0, bus.overflow}, 32'd0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    exp_t me;
    bit done_seen;

    initial begin
        tbl[0] = '{s0: 2'd1, s1: 2'd2, len: 8'd3, step: 1'b0, i0: 8'h00, i1: 8'h00, res: 9'd18,  ovf: 1'b0};
        tbl[1] = '{s0: 2'd3, s1: 2'd3, len: 8'd4, step: 1'b1, i0: 8'h10, i1: 8'h20, res: 9'd69,  ovf: 1'b0};
        tbl[2] = '{s0: 2'd2, s1: 2'd1, len: 8'd0, step: 1'b1, i0: 8'h33, i1: 8'h44, res: 9'd0,   ovf: 1'b0};
        tbl[3] = '{s0: 2'd0, s1: 2'd0, len: 8'd2, step: 1'b0, i0: 8'hFF, i1: 8'hFF, res: 9'd508, ovf: 1'b1};
        tbl[4] = '{s0: 2'd0, s1: 2'd0, len: 8'd1, step: 1'b0, i0: 8'h03, i1: 8'h04, res: 9'd7,   ovf: 1'b0};
        tbl[5] = '{s0: 2'd0, s1: 2'd1, len: 8'd6, step: 1'b1, i0: 8'h80, i1: 8'h40, res: 9'd351, ovf: 1'b0};
        tbl[6] = '{s0: 2'd0, s1: 2'd0, len: 8'd3, step: 1'b0, i0: 8'hC8, i1: 8'h64, res: 9'd388, ovf: 1'b1};
        tbl[7] = '{s0: 2'd2, s1: 2'd0, len: 8'd5, step: 1'b0, i0: 8'h00, i1: 8'h11, res: 9'd95,  ovf: 1'b0};

        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_sel0  = 2'd0;
        bus.cmd_sel1  = 2'd0;
        bus.cmd_len   = '0;
        bus.cmd_step  = 1'b0;
        bus.abort     = 1'b0;
        in0 = 8'h00;
        in1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");
        @(negedge clk);
        chk_reset_state("idle");

        for (int i = 0; i < 8; i++) run(tbl[i], 1'b0);

        for (int i = 0; i < 4; i++) begin
            rv.s0   = 2'($urandom_range(0, 3));
            rv.s1   = 2'($urandom_range(0, 3));
            rv.len  = 8'($urandom_range(0, 7));
            rv.step = 1'($urandom_range(0, 1));
            rv.i0   = 8'($urandom_range(0, 255));
            rv.i1   = 8'($urandom_range(0, 255));
            me = model(rv);
            rv.res = me.res;
            rv.ovf = me.ovf;
            run(rv, 1'b0);
        end

        // abort with cmd_valid in IDLE still accepts the command
        run(tbl[0], 1'b1);

        // abort alone in IDLE is ignored
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("idle_abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("idle_abort_busy", {31'd0, bus.busy}, 32'd0);

        // abort in the 2nd RUN cycle of a len=5 run
        start(2'd1, 2'd2, 8'd5, 1'b1, 8'h21, 8'h42);
        chk("abort_run_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("abort_sel_0", {30'd0, bus.sel_0}, 32'd0);
        chk("abort_sel_1", {30'd0, bus.sel_1}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", {31'd0, done_seen}, 32'd0);

        // reset in the 2nd RUN cycle of a len=5 run
        start(2'd0, 2'd0, 8'd5, 1'b0, 8'h55, 8'h66);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("midrun_rst");
        done_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_no_done", {31'd0, done_seen}, 32'd0);

        // the controller is still usable afterwards
        run(tbl[1], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
